game_scheduler: RTL and testbench

Central sequencer for the game loop. Derives a once-per-frame tick from the VGA scan position and runs the game-state FSM (idle / playing / won / lost). During vertical blanking it issues ordered single-cycle enable strobes to the player, bullet and invader blocks, so all game state changes off-screen and sprite_drawer always sees a stable frame. It also owns invader speed-up and a hit counter, and replaces the gameplay block's state output.

---
 rtl/game_pkg.sv | 21 ++
 rtl/frame_divider.sv | 27 ++
 rtl/game_scheduler.sv | 134 +++++++++++++
 tb/tb_game_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level definitions: gameplay state encodings and grid geometry.
package game_pkg;

  typedef enum logic [1:0] {
    GP_IDLE    = 2'b00,
    GP_PLAYING = 2'b01,
    GP_WON     = 2'b10,
    GP_LOST    = 2'b11
  } gameplay_t;

  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int GRID_CELLS       = 20;

  function automatic logic [4:0] popcount(input logic [GRID_CELLS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < GRID_CELLS; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Frame-rate divider: counts ticks and flags the tick on which count >= period, then restarts.
// wrap is combinational from tick so the caller can latch it in the tick cycle.
module frame_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic [WIDTH-1:0] period,
  output logic             wrap
);

  logic [WIDTH-1:0] count;

  // >= rather than == so a period that shrinks under the count still wraps at once
  assign wrap = tick && (count >= period);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/game_scheduler.sv
// Game-loop sequencer: per-frame tick, gameplay FSM, and ordered blanking-time step strobes.
// Strobes land at T+1..T+3 after the tick; status is evaluated so the new state shows at T+4.
module game_scheduler
  import game_pkg::*;
#(
  parameter int V_ACTIVE       = V_ACTIVE_DEFAULT,
  parameter int BULLET_DIV     = 2,
  parameter int INV_PERIOD_MIN = 4,
  parameter int LOSE_LINE      = 12,
  parameter int RESULT_HOLD    = 120
) (
  input  logic        i_clk_25MHz,
  input  logic        i_reset,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic        i_start,
  input  logic        i_hit,
  input  logic [19:0] i_invaders_array,
  input  logic [3:0]  i_invaders_line,
  output logic [1:0]  o_gameplay,
  output logic        o_restart,
  output logic        o_frame_tick,
  output logic        o_player_en,
  output logic        o_bullet_en,
  output logic        o_invaders_en,
  output logic [7:0]  o_score
);

  gameplay_t  state;
  logic [1:0] phase;
  logic [7:0] hold;
  logic       start_q;
  logic       bul_go, inv_go;
  logic       bul_wrap, inv_wrap;
  logic       tick_hit, start_rise, playing, div_tick, div_clear;
  logic [4:0] inv_period;

  assign tick_hit   = (i_x == 10'd0) && (i_y == 10'(V_ACTIVE));
  assign start_rise = i_start && !start_q;
  assign playing    = (state == GP_PLAYING);
  assign div_tick   = o_frame_tick && playing;
  assign div_clear  = (state == GP_IDLE) && start_rise;
  assign inv_period = 5'(INV_PERIOD_MIN) + popcount(i_invaders_array);
  assign o_gameplay = state;

  frame_divider #(.WIDTH(4)) u_bullet_div (
    .clk    (i_clk_25MHz),
    .reset  (i_reset),
    .tick   (div_tick),
    .clear  (div_clear),
    .period (4'(BULLET_DIV - 1)),
    .wrap   (bul_wrap)
  );

  frame_divider #(.WIDTH(5)) u_invader_div (
    .clk    (i_clk_25MHz),
    .reset  (i_reset),
    .tick   (div_tick),
    .clear  (div_clear),
    .period (inv_period),
    .wrap   (inv_wrap)
  );

  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      state         <= GP_IDLE;
      phase         <= 2'd0;
      hold          <= 8'd0;
      start_q       <= i_start;
      bul_go        <= 1'b0;
      inv_go        <= 1'b0;
      o_restart     <= 1'b0;
      o_frame_tick  <= 1'b0;
      o_player_en   <= 1'b0;
      o_bullet_en   <= 1'b0;
      o_invaders_en <= 1'b0;
      o_score       <= 8'd0;
    end else begin
      start_q       <= i_start;
      o_frame_tick  <= tick_hit;
      o_restart     <= 1'b0;
      o_player_en   <= 1'b0;
      o_bullet_en   <= 1'b0;
      o_invaders_en <= 1'b0;

      // a hit coinciding with the restart pulse is lost to the clear
      if (playing && i_hit && !o_restart && (o_score != 8'hFF)) o_score <= o_score + 8'd1;

      case (state)
        GP_IDLE: begin
          if (start_rise) begin
            state     <= GP_PLAYING;
            o_restart <= 1'b1;
            o_score   <= 8'd0;
            phase     <= 2'd0;
          end
        end
        GP_PLAYING: begin
          case (phase)
            2'd0: begin
              if (o_frame_tick) begin
                phase       <= 2'd1;
                o_player_en <= 1'b1;
                bul_go      <= bul_wrap;
                inv_go      <= inv_wrap;
              end
            end
            2'd1: begin
              phase       <= 2'd2;
              o_bullet_en <= bul_go;
            end
            2'd2: begin
              phase         <= 2'd3;
              o_invaders_en <= inv_go;
            end
            default: begin
              phase <= 2'd0;
              hold  <= 8'd0;
              if (i_invaders_array == '0)                 state <= GP_WON;
              else if (i_invaders_line >= 4'(LOSE_LINE))  state <= GP_LOST;
            end
          endcase
        end
        default: begin
          if (o_frame_tick) begin
            if (hold == 8'(RESULT_HOLD - 1)) state <= GP_IDLE;
            else                             hold  <= hold + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_scheduler.sv
// Scenario bench for game_scheduler using short synthetic frames and a frame-level reference model.
module tb_game_scheduler;

  localparam int V_ACTIVE    = 480;
  localparam int BULLET_DIV  = 2;
  localparam int INV_MIN     = 4;
  localparam int LOSE_LINE   = 12;
  localparam int RESULT_HOLD = 120;
  localparam int FRAME_LEN   = 12;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [9:0]  i_x = 10'd5;
  logic [9:0]  i_y = 10'd5;
  logic        i_start = 1'b0;
  logic        i_hit = 1'b0;
  logic [19:0] inv_arr = '1;
  logic [3:0]  inv_line = 4'd0;
  logic [1:0]  o_gameplay;
  logic        o_restart, o_frame_tick, o_player_en, o_bullet_en, o_invaders_en;
  logic [7:0]  o_score;

  int cmp_count  = 0;
  int fail_count = 0;

  // reference model: game state, frames since last bullet/invader step, hold frames, score
  int m_state = 0;
  int m_bul   = 0;
  int m_inv   = 0;
  int m_hold  = 0;
  int m_score = 0;

  always #20 clk = ~clk;

  game_scheduler dut (
    .i_clk_25MHz      (clk),
    .i_reset          (i_reset),
    .i_x              (i_x),
    .i_y              (i_y),
    .i_start          (i_start),
    .i_hit            (i_hit),
    .i_invaders_array (inv_arr),
    .i_invaders_line  (inv_line),
    .o_gameplay       (o_gameplay),
    .o_restart        (o_restart),
    .o_frame_tick     (o_frame_tick),
    .o_player_en      (o_player_en),
    .o_bullet_en      (o_bullet_en),
    .o_invaders_en    (o_invaders_en),
    .o_score          (o_score)
  );

  task automatic cycle(input logic tick);
    if (tick) begin
      i_x = 10'd0;
      i_y = 10'(V_ACTIVE);
    end else begin
      i_x = 10'($urandom_range(1, 799));
      i_y = 10'($urandom_range(0, 524));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int hits);
    int st0, next_st, period;
    logic exp_bul, exp_inv;
    logic [4:0] exp_v, got_v;
    int exp_gp;
    st0 = m_state; next_st = m_state; exp_bul = 1'b0; exp_inv = 1'b0;
    if (m_state == 1) begin
      period  = INV_MIN + $countones(inv_arr);
      exp_bul = (m_bul == BULLET_DIV - 1);
      m_bul   = exp_bul ? 0 : m_bul + 1;
      exp_inv = (m_inv >= period);
      m_inv   = exp_inv ? 0 : m_inv + 1;
      if (inv_arr == '0)                 next_st = 2;
      else if (int'(inv_line) >= LOSE_LINE) next_st = 3;
      if (next_st != 1) m_hold = 0;
    end else if (m_state >= 2) begin
      m_hold++;
      if (m_hold == RESULT_HOLD) next_st = 0;
    end
    for (int k = 0; k < FRAME_LEN; k++) begin
      i_hit = (k >= 5 && k < 5 + hits);
      cycle(k == 0);
      if (i_hit && next_st == 1 && m_score < 255) m_score++;
      exp_v = {k == 0, st0 == 1 && k == 1, st0 == 1 && k == 2 && exp_bul,
               st0 == 1 && k == 3 && exp_inv, 1'b0};
      got_v = {o_frame_tick, o_player_en, o_bullet_en, o_invaders_en, o_restart};
      cmp_count++;
      if (got_v !== exp_v) begin
        fail_count++;
        $display("FAIL frame_strobes k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
      if (st0 == 1) exp_gp = (k < 4) ? st0 : next_st;
      else          exp_gp = (k < 1) ? st0 : next_st;
      cmp_count++;
      if (o_gameplay !== 2'(exp_gp)) begin
        fail_count++;
        $display("FAIL frame_gameplay k=%0d got=%0d exp=%0d", k, o_gameplay, exp_gp);
      end
    end
    i_hit = 1'b0;
    m_state = next_st;
    cmp_count++;
    if (o_score !== 8'(m_score)) begin
      fail_count++;
      $display("FAIL frame_score got=%0d exp=%0d", o_score, m_score);
    end
  endtask

  task automatic start_game(input logic hit_on_restart);
    i_start = 1'b0;
    cycle(1'b0);
    i_start = 1'b1;
    cycle(1'b0);
    cmp_count++;
    if (o_restart !== 1'b1 || o_gameplay !== 2'b01) begin
      fail_count++;
      $display("FAIL start_entry got restart=%b gp=%b exp restart=1 gp=01", o_restart, o_gameplay);
    end
    i_hit = hit_on_restart;
    cycle(1'b0);
    i_hit = 1'b0;
    i_start = 1'b0;
    m_state = 1; m_bul = 0; m_inv = 0; m_score = 0;
    cmp_count++;
    if (o_restart !== 1'b0 || o_gameplay !== 2'b01 || o_score !== 8'd0) begin
      fail_count++;
      $display("FAIL start_after got restart=%b gp=%b score=%0d exp 0/01/0", o_restart, o_gameplay, o_score);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    cmp_count++;
    if ({o_gameplay, o_restart, o_frame_tick, o_player_en, o_bullet_en, o_invaders_en} !== 7'd0
        || o_score !== 8'd0) begin
      fail_count++;
      $display("FAIL reset_outputs got gp=%b r=%b t=%b p=%b b=%b i=%b score=%0d exp all 0",
               o_gameplay, o_restart, o_frame_tick, o_player_en, o_bullet_en, o_invaders_en, o_score);
    end
    i_reset = 1'b0;
    m_state = 0; m_bul = 0; m_inv = 0; m_hold = 0; m_score = 0;
  endtask

  task automatic hit_burst(input int n);
    for (int i = 0; i < n; i++) begin
      i_hit = 1'b1;
      cycle(1'b0);
      i_hit = 1'b0;
      cycle(1'b0);
      if (m_state == 1 && m_score < 255) m_score++;
    end
    cmp_count++;
    if (o_score !== 8'(m_score)) begin
      fail_count++;
      $display("FAIL hit_burst_score got=%0d exp=%0d", o_score, m_score);
    end
  endtask

  task automatic test_reset();
    i_start = 1'b1;
    do_reset();
    run_frame(0);
    run_frame(0);
    start_game(1'b1);
  endtask

  task automatic test_all_ones();
    inv_arr = '1; inv_line = 4'd0;
    for (int f = 0; f < 52; f++) run_frame(0);
  endtask

  task automatic test_one_invader_win();
    inv_arr = '0;
    inv_arr[$urandom_range(0, 19)] = 1'b1;
    for (int f = 0; f < 13; f++) run_frame(0);
    inv_arr = '0;
    run_frame(0);
    i_start = 1'b1;
    for (int f = 0; f < RESULT_HOLD; f++) run_frame(0);
    run_frame(0);
    i_start = 1'b0;
  endtask

  task automatic test_lose_and_priority();
    start_game(1'b0);
    inv_arr = 20'($urandom_range(1, 20'hFFFFF)); inv_line = 4'd12;
    run_frame(0);
    do_reset();
    start_game(1'b0);
    inv_arr = '0;
    run_frame(0);
    do_reset();
    inv_line = 4'd0;
  endtask

  task automatic test_score();
    start_game(1'b0);
    inv_arr = 20'($urandom_range(1, 20'hFFFFF));
    hit_burst(300);
    run_frame(3);
    inv_arr = '0;
    run_frame(2);
    for (int f = 0; f < RESULT_HOLD; f++) run_frame(f % 3);
    hit_burst(4);
    start_game(1'b0);
  endtask

  task automatic test_random_play();
    for (int f = 0; f < 40; f++) begin
      inv_arr  = 20'($urandom_range(1, 20'hFFFFF));
      inv_line = 4'($urandom_range(0, LOSE_LINE - 1));
      run_frame(int'($urandom_range(0, 6)));
    end
  endtask

  task automatic test_reset_midgame();
    logic [4:0] got_v;
    inv_arr = '1; inv_line = 4'd0;
    cycle(1'b1);
    cycle(1'b0);
    cmp_count++;
    if (o_player_en !== 1'b1) begin
      fail_count++;
      $display("FAIL midgame_player got=%b exp=1", o_player_en);
    end
    cycle(1'b0);
    i_reset = 1'b1;
    cycle(1'b0);
    i_reset = 1'b0;
    m_state = 0; m_bul = 0; m_inv = 0; m_hold = 0; m_score = 0;
    for (int k = 3; k < FRAME_LEN; k++) begin
      if (k > 3) cycle(1'b0);
      got_v = {o_player_en, o_bullet_en, o_invaders_en, o_restart, o_frame_tick};
      cmp_count++;
      if (o_gameplay !== 2'b00 || got_v !== 5'd0 || o_score !== 8'd0) begin
        fail_count++;
        $display("FAIL midgame_reset k=%0d got gp=%b strobes=%b score=%0d exp 00/00000/0",
                 k, o_gameplay, got_v, o_score);
      end
    end
    run_frame(2);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_all_ones();
    test_one_invader_win();
    test_lose_and_priority();
    test_score();
    test_random_play();
    test_reset_midgame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
